vram_scanout: RTL and testbench
===============================

# vram_scanout

Display read engine for the video RAM's byte-wide read port. It generates 640x480@60 VGA timing at the pixel clock and fetches a 512x384 1-bpp bitmap, one byte per 8 pixels, through the VRAM's registered read port. It serialises each byte MSB-first into 24-bit RGB, with a border colour outside the bitmap window. It also gives the 68k a vertical-blank interrupt pulse and a per-frame vertical scroll.

## Interface
- FG_RGB, 24'hFFFFFF, colour of a set bitmap bit
- BG_RGB, 24'h000000, colour of a clear bitmap bit
- BORDER_RGB, 24'h0000AA, colour inside the active area but outside the bitmap window
- clk  in  1  pixel clock, 25 MHz; the only clock
- reset  in  1  synchronous, active-high
- vscroll  in  9  vertical scroll in bitmap lines; sampled once per frame
- addr_b  out  15  VRAM byte address (registered)
- din_b  in  8  VRAM read data; registered in VRAM, valid 1 clk after addr_b
- hsync_n  out  1  horizontal sync, active-low
- vsync_n  out  1  vertical sync, active-low
- de  out  1  display enable (640x480 active area)
- red, green, blue  out  8 each  pixel colour
- vblank_irq  out  1  one-cycle pulse at start of vertical blank

## Operation
- Internal counters: hc 0..799, vc 0..524. hc wraps 799→0 and advances vc; vc wraps 524→0.
- Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Bitmap window: x 64..575, y 48..431. Window line w = y−48; bitmap line L = (w + vs) mod 384.
- Byte address: L*64 + (x−64)/8. The maximum is 24575, so addr_b[14:13] never reaches 2'b11.
- Pixel colour: bit 7−((x−64) mod 8) of that byte; 1 gives FG_RGB, 0 gives BG_RGB.
- Active pixels outside the window show BORDER_RGB. red/green/blue are 0 whenever de=0.
- vs is latched from vscroll at the first cycle of line 480, so a mid-frame write never tears the frame.
- If vscroll ≥ 384, vs = vscroll − 384.
- Fetch: one addr_b per 8-pixel group, issued early enough to absorb addr_b register + VRAM read register. Then load an 8-bit shifter.
- addr_b holds its last value when not fetching and is 0 after reset.
- Reset values: counters 0, hsync_n=1, vsync_n=1, de=0, rgb=0, addr_b=0, vblank_irq=0, vs=0, shifter 0.

## Timing
- hsync_n, vsync_n, de, rgb and vblank_irq are all registered and aligned to the same pixel. They lag the internal counters by a fixed 2 clk.
- After reset deasserts, outputs hold reset values for 2 clk. The third cycle is output pixel (0,0) with de=1.
- vblank_irq is high for exactly the 1 clk that coincides with output pixel h=0 of line 480, once per frame.
- Reset asserted mid-frame: all outputs take reset values at the next edge. Pipeline and pending fetch are discarded, and timing restarts at line 0 exactly as after power-up.
- Read latency assumed is exactly 1 clk (din_b valid the cycle after addr_b). din_b is ignored outside fetch slots.
- Frame: 800x525 = 420000 clk.

## Test plan
- Reset: hold reset 5 clk, then release.
  - During reset: hsync_n=vsync_n=1, de=0, rgb=0, addr_b=0, vblank_irq=0.
  - First de=1 exactly 3 cycles after release.
- Timing over 2 frames:
  - Every line is 800 clk, every frame 525 lines.
  - de high 640 consecutive clk on lines 0..479 only.
  - hsync_n low 96 clk, starting 16 clk after de falls.
  - vsync_n low for lines 490..491.
  - vblank_irq exactly once per 420000 clk.
- Pixel mapping, VRAM model with byte0=0x81, byte63=0x01, all others 0, vscroll=0:
  - Line 48: columns 64 and 71 are FG; columns 65..70 are BG; column 575 is FG.
  - Columns 0..63 and 576..639 are BORDER.
  - Line 47 is all BORDER.
- Scroll wrap: write vscroll=383 mid-frame.
  - The current frame still fetches byte 0 at line 48.
  - Next frame: line 48 fetches 24512..24575, line 49 fetches 0..63.
- Out-of-range scroll: vscroll=400 → line 48 fetches 1024; no addr_b ≥ 24576 ever appears.
- Reset mid-operation: pulse reset for 1 clk at output line 100, column 300.
  - Outputs take reset values the next cycle.
  - de rises 3 clk after release; the line counts from 0 again with the correct vsync position.

Source files
------------

// File: rtl/vram_scanout_if.sv
// rtl/vram_scanout_if.sv - byte-wide VRAM read port between scanout and video RAM
interface vram_scanout_if;
    logic [14:0] addr_b;
    logic [7:0]  din_b;

    modport master (output addr_b, input din_b);
    modport slave  (input addr_b, output din_b);
endinterface

// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - 640x480@60 VGA scanout of a 512x384 1-bpp VRAM bitmap with border, scroll and vblank irq
module vram_scanout #(
    parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h000000,
    parameter logic [23:0] BORDER_RGB = 24'h0000AA,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          WIN_Y0     = 48,
    parameter int          WIN_H      = 384
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [8:0]     vscroll,
    vram_scanout_if.master vram,
    output logic           hsync_n,
    output logic           vsync_n,
    output logic           de,
    output logic [7:0]     red,
    output logic [7:0]     green,
    output logic [7:0]     blue,
    output logic           vblank_irq
);
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_FIRST = 10'd656;
    localparam logic [9:0] H_SYNC_LAST  = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] WIN_X_FIRST  = 10'd64;
    localparam logic [9:0] WIN_X_LAST   = 10'd575;
    localparam logic [9:0] FETCH_FIRST  = 10'd62;
    localparam logic [9:0] FETCH_LAST   = 10'd566;
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] WIN_Y_FIRST  = 10'(WIN_Y0);
    localparam logic [9:0] WIN_Y_LAST   = 10'(WIN_Y0 + WIN_H - 1);
    localparam logic [9:0] BMP_H        = 10'(WIN_H);
    localparam logic [8:0] SCROLL_H     = 9'(WIN_H);

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [8:0]  vs;
    logic [7:0]  shifter;
    logic [23:0] rgb;

    logic        de_d1;
    logic        hs_d1;
    logic        vsy_d1;
    logic        win_d1;
    logic        irq_d1;

    logic        de_c;
    logic        win_y_c;
    logic        win_c;
    logic        fetch_c;
    logic        load_c;
    logic        frame_mark_c;
    logic [9:0]  line_sum;
    logic [8:0]  line_l;
    logic [5:0]  col;

    // Fetch for the group starting at x is issued at hc = x-2: one clk for the
    // addr_b register, one for the VRAM read register, then the shifter loads at hc = x.
    always_comb begin
        de_c         = (hc < H_ACTIVE) && (vc < V_ACT);
        win_y_c      = (vc >= WIN_Y_FIRST) && (vc <= WIN_Y_LAST);
        win_c        = win_y_c && (hc >= WIN_X_FIRST) && (hc <= WIN_X_LAST);
        fetch_c      = win_y_c && (hc >= FETCH_FIRST) && (hc <= FETCH_LAST) && (hc[2:0] == 3'd6);
        load_c       = win_c && (hc[2:0] == 3'd0);
        frame_mark_c = (hc == 10'd0) && (vc == V_ACT);
        line_sum     = (vc - WIN_Y_FIRST) + {1'b0, vs};
        line_l       = (line_sum >= BMP_H) ? 9'(line_sum - BMP_H) : line_sum[8:0];
        col          = hc[8:3] - 6'd7;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    // Scroll is captured at the start of vertical blank so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs <= '0;
        end else if (frame_mark_c) begin
            vs <= (vscroll >= SCROLL_H) ? vscroll - SCROLL_H : vscroll;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram.addr_b <= '0;
        end else if (fetch_c) begin
            vram.addr_b <= {line_l, col};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shifter <= '0;
        end else if (load_c) begin
            shifter <= vram.din_b;
        end else begin
            shifter <= {shifter[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de_d1  <= 1'b0;
            hs_d1  <= 1'b1;
            vsy_d1 <= 1'b1;
            win_d1 <= 1'b0;
            irq_d1 <= 1'b0;
        end else begin
            de_d1  <= de_c;
            hs_d1  <= !((hc >= H_SYNC_FIRST) && (hc <= H_SYNC_LAST));
            vsy_d1 <= !((vc >= V_SYNC_FIRST) && (vc <= V_SYNC_LAST));
            win_d1 <= win_c;
            irq_d1 <= frame_mark_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_n    <= 1'b1;
            vsync_n    <= 1'b1;
            de         <= 1'b0;
            vblank_irq <= 1'b0;
            rgb        <= '0;
        end else begin
            hsync_n    <= hs_d1;
            vsync_n    <= vsy_d1;
            de         <= de_d1;
            vblank_irq <= irq_d1;
            if (!de_d1) begin
                rgb <= '0;
            end else if (win_d1) begin
                rgb <= shifter[7] ? FG_RGB : BG_RGB;
            end else begin
                rgb <= BORDER_RGB;
            end
        end
    end

    assign red   = rgb[23:16];
    assign green = rgb[15:8];
    assign blue  = rgb[7:0];
endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - bench for vram_scanout using a shortened vertical frame
module tb_vram_scanout;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int WIN_Y0   = 2;
    localparam int WIN_H    = 8;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_TOTAL  = 800;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam logic [23:0] FG     = 24'hFFFFFF;
    localparam logic [23:0] BG     = 24'h000000;
    localparam logic [23:0] BORDER = 24'h0000AA;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] vscroll = 9'd0;
    logic       hsync_n;
    logic       vsync_n;
    logic       de;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       vblank_irq;

    vram_scanout_if vif();

    vram_scanout #(
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .WIN_Y0   (WIN_Y0),
        .WIN_H    (WIN_H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vscroll    (vscroll),
        .vram       (vif.master),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .de         (de),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .vblank_irq (vblank_irq)
    );

    always #5 clk = ~clk;

    logic [7:0] vram_mem [0:32767];
    initial begin
        for (int i = 0; i < 32768; i++) vram_mem[i] = 8'h00;
        vram_mem[0]  = 8'h81;
        vram_mem[63] = 8'h01;
    end

    always @(posedge clk) vif.din_b <= vram_mem[vif.addr_b];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [27:0] vid;
        bit          chk_addr;
        logic [14:0] addr;
        int          x;
        int          y;
        int          frame;
    } exp_t;

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [23:0] rgb;
        int          addr;
    } dir_t;

    exp_t sb[$];
    dir_t dir_tab[$];

    int checks   = 0;
    int failures = 0;
    int irq_cnt  = 0;
    int vsync_cnt = 0;

    initial begin
        dir_tab.push_back('{0,  64, 2, FG,     0});
        dir_tab.push_back('{0,  65, 2, BG,    -1});
        dir_tab.push_back('{0,  70, 2, BG,    -1});
        dir_tab.push_back('{0,  71, 2, FG,    -1});
        dir_tab.push_back('{0, 568, 2, BG,    63});
        dir_tab.push_back('{0, 575, 2, FG,    -1});
        dir_tab.push_back('{0,   0, 2, BORDER, -1});
        dir_tab.push_back('{0,  63, 2, BORDER, -1});
        dir_tab.push_back('{0, 576, 2, BORDER, -1});
        dir_tab.push_back('{0, 639, 2, BORDER, -1});
        dir_tab.push_back('{0, 640, 2, 24'h0,  -1});
        dir_tab.push_back('{0,  64, 1, BORDER, -1});
        dir_tab.push_back('{0,  64, 3, BG,    64});
        dir_tab.push_back('{1,  64, 2, BG,   448});
        dir_tab.push_back('{1, 568, 2, BG,   511});
        dir_tab.push_back('{1,  64, 3, FG,     0});
        dir_tab.push_back('{1, 575, 3, FG,    -1});
        dir_tab.push_back('{2,  64, 2, BG,   128});
        dir_tab.push_back('{3,  64, 2, FG,     0});
    end

    function automatic int model_addr(int x, int y, int vsv);
        return ((y - WIN_Y0 + vsv) % WIN_H) * 64 + (x - 64) / 8;
    endfunction

    function automatic logic [23:0] model_rgb(int x, int y, int vsv);
        int a;
        if (x >= 640 || y >= V_ACTIVE) return 24'h0;
        if (x < 64 || x > 575 || y < WIN_Y0 || y >= WIN_Y0 + WIN_H) return BORDER;
        a = model_addr(x, y, vsv);
        return vram_mem[a][7 - ((x - 64) % 8)] ? FG : BG;
    endfunction

    int n        = 0;
    int frame_no = -1;
    int model_vs = 0;

    task automatic produce();
        exp_t e;
        int p, x, y;
        logic hs, vsy, den, irq;
        if (reset) begin
            n = 0;
            model_vs = 0;
        end else begin
            n = n + 1;
        end
        e.x = -1; e.y = -1; e.frame = -1; e.chk_addr = 1'b0; e.addr = '0;
        if (n < 2) begin
            e.vid = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
            e.chk_addr = 1'b1;
        end else begin
            p = n - 2;
            x = p % H_TOTAL;
            y = (p / H_TOTAL) % V_TOTAL;
            if (x == 0 && y == 0) frame_no++;
            if (x == 0 && y == V_ACTIVE) model_vs = int'(vscroll) % WIN_H;
            hs  = !(x >= 656 && x <= 751);
            vsy = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
            den = (x < 640) && (y < V_ACTIVE);
            irq = (x == 0) && (y == V_ACTIVE);
            e.vid = {hs, vsy, den, irq, model_rgb(x, y, model_vs)};
            e.x = x; e.y = y; e.frame = frame_no;
            if (y >= WIN_Y0 && y < WIN_Y0 + WIN_H && x >= 64 && x <= 575 && ((x - 64) % 8) == 0) begin
                e.chk_addr = 1'b1;
                e.addr = 15'(model_addr(x, y, model_vs));
            end
        end
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        produce();
    end

    initial forever begin
        exp_t e;
        logic [27:0] got;
        @(negedge clk);
        if (!vblank_irq) begin end else irq_cnt++;
        if (!vsync_n) vsync_cnt++;
        checks++;
        if (vif.addr_b >= 15'(WIN_H * 64)) begin
            failures++;
            $display("FAIL addr_range got=%0d limit=%0d", vif.addr_b, WIN_H * 64);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {hsync_n, vsync_n, de, vblank_irq, red, green, blue};
            checks++;
            if (got !== e.vid) begin
                failures++;
                $display("FAIL video f=%0d x=%0d y=%0d got=%h exp=%h", e.frame, e.x, e.y, got, e.vid);
            end
            if (e.chk_addr) begin
                checks++;
                if (vif.addr_b !== e.addr) begin
                    failures++;
                    $display("FAIL addr f=%0d x=%0d y=%0d got=%0d exp=%0d", e.frame, e.x, e.y, vif.addr_b, e.addr);
                end
            end
            foreach (dir_tab[i]) begin
                if (dir_tab[i].f == e.frame && dir_tab[i].x == e.x && dir_tab[i].y == e.y) begin
                    checks++;
                    if ({red, green, blue} !== dir_tab[i].rgb) begin
                        failures++;
                        $display("FAIL pixel f=%0d x=%0d y=%0d got=%h exp=%h", e.frame, e.x, e.y, {red, green, blue}, dir_tab[i].rgb);
                    end
                    if (dir_tab[i].addr >= 0) begin
                        checks++;
                        if (int'(vif.addr_b) != dir_tab[i].addr) begin
                            failures++;
                            $display("FAIL fetch f=%0d x=%0d y=%0d got=%0d exp=%0d", e.frame, e.x, e.y, vif.addr_b, dir_tab[i].addr);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_pixel(input int c_rel, input int p);
        while (cyc < c_rel + p + 2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_first_de(input string name);
        int first_de;
        first_de = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (de && first_de == 0) first_de = k;
        end
        checks++;
        if (first_de != 3) begin
            failures++;
            $display("FAIL %s first_de_cycle got=%0d exp=3", name, first_de);
        end
    endtask

    initial begin
        int c_rel;
        reset = 1'b1;
        vscroll = 9'd0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        c_rel = cyc;
        check_first_de("power_up");

        wait_pixel(c_rel, 1 * H_TOTAL);
        vscroll = 9'd7;
        wait_pixel(c_rel, FRAME + 1 * H_TOTAL);
        vscroll = 9'd10;

        wait_pixel(c_rel, 2 * FRAME + 5 * H_TOTAL + 300);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        c_rel = cyc;
        check_first_de("mid_reset");

        wait_pixel(c_rel, 17 * H_TOTAL + 10);
        repeat (3) @(posedge clk);
        #1;

        checks++;
        if (irq_cnt != 3) begin
            failures++;
            $display("FAIL irq_count got=%0d exp=3", irq_cnt);
        end
        checks++;
        if (vsync_cnt != 3 * V_SYNC * H_TOTAL) begin
            failures++;
            $display("FAIL vsync_low_cycles got=%0d exp=%0d", vsync_cnt, 3 * V_SYNC * H_TOTAL);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
